// File: rtl/alu_seq.sv
// Registered ALU with ADD/SUB/AND/OR/XOR/SHL/SHR and an iterative shift-add MUL.
// Latency: 1 cycle for ops 0-6; MUL presents its result WIDTH+1 edges after accept.
// Backpressure: a held result blocks new operands until out_ready takes it (pass-through on same edge).
module alu_seq #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  // Shift staging is wide enough to keep every bit a maximal left shift can push out.
  localparam int SW = WIDTH + (1 << SHW);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [CW-1:0]        cnt;

  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [SW-1:0]        shl_wide;
  logic [WIDTH-1:0]     c_res;
  logic                 c_carry;
  logic                 c_ovf;

  logic                 accept;

  assign out_valid = (state == HOLD);
  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;

  // Single-cycle datapath: result and flags for ops 0-6 from the live operands.
  always_comb begin
    c_res    = '0;
    c_carry  = 1'b0;
    c_ovf    = 1'b0;
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    shl_wide = SW'(a) << b[SHW-1:0];
    case (op)
      OP_ADD: begin
        c_res   = sum[WIDTH-1:0];
        c_carry = sum[WIDTH];
        c_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        c_res   = diff[WIDTH-1:0];
        c_carry = diff[WIDTH];
        c_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: c_res = a & b;
      OP_OR:  c_res = a | b;
      OP_XOR: c_res = a ^ b;
      OP_SHL: begin
        c_res = shl_wide[WIDTH-1:0];
        c_ovf = |shl_wide[SW-1:WIDTH];
      end
      OP_SHR: c_res = a >> b[SHW-1:0];
      default: ;
    endcase
  end

  // Control FSM with registered result/flags and the shift-add multiplier state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      acc      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            if (op == OP_MUL) begin
              a_sh  <= {{WIDTH{1'b0}}, a};
              b_sh  <= b;
              acc   <= '0;
              cnt   <= '0;
              state <= BUSY;
            end else begin
              result   <= c_res;
              carry    <= c_carry;
              overflow <= c_ovf;
              zero     <= (c_res == '0);
              state    <= HOLD;
            end
          end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          // One extra edge after the last iteration publishes the product.
          if (cnt == CW'(WIDTH)) begin
            result   <= acc[WIDTH-1:0];
            carry    <= 1'b0;
            overflow <= |acc[2*WIDTH-1:WIDTH];
            zero     <= (acc[WIDTH-1:0] == '0);
            state    <= HOLD;
          end else begin
            if (b_sh[0]) acc <= acc + a_sh;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
